// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, IF/ID register,
// 1-entry skid buffer for ID stalls and squash of in-flight requests.
module if_fetch_unit #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [29:0] pc,
   output logic        pc_write,
   output logic        imem_req,
   output logic [29:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        id_stall,
   input  logic        flush,
   output logic        ifid_valid,
   output logic [31:0] ifid_instr,
   output logic [29:0] ifid_pc4
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic        skid_valid;
   logic [31:0] skid_instr;
   logic [29:0] skid_pc4;
   logic [29:0] drop_addr;
   logic        can_load;
   logic        complete;
   logic        skid_drain;
   logic [29:0] fetch_pc4;

   assign can_load   = !ifid_valid || !id_stall;
   assign complete   = (state == WAIT) && imem_ack && !flush;
   assign skid_drain = skid_valid && can_load && !flush;
   assign fetch_pc4  = pc + 30'd1;

   assign pc_write  = complete || flush;
   assign imem_req  = (state == WAIT) || (state == DROP);
   assign imem_addr = (state == DROP) ? drop_addr : pc;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (flush || !skid_valid || can_load)
               state_nx = WAIT;
         end
         WAIT: begin
            if (flush)
               state_nx = imem_ack ? WAIT : DROP;
            else if (complete && (skid_valid || !can_load))
               state_nx = IDLE;
         end
         DROP: begin
            if (imem_ack)
               state_nx = WAIT;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ifid_valid <= 1'b0;
         ifid_instr <= NOP_INSTR;
         ifid_pc4   <= 30'd0;
         skid_valid <= 1'b0;
         skid_instr <= NOP_INSTR;
         skid_pc4   <= 30'd0;
         drop_addr  <= 30'd0;
      end else begin
         state <= state_nx;
         // remember the squashed address so the request stays stable
         if ((state == WAIT) && flush && !imem_ack)
            drop_addr <= pc;
         if (flush) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
            skid_valid <= 1'b0;
            skid_instr <= NOP_INSTR;
         end else if (skid_drain) begin
            ifid_valid <= 1'b1;
            ifid_instr <= skid_instr;
            ifid_pc4   <= skid_pc4;
            skid_valid <= complete;
            if (complete) begin
               skid_instr <= imem_rdata;
               skid_pc4   <= fetch_pc4;
            end
         end else if (complete && can_load) begin
            ifid_valid <= 1'b1;
            ifid_instr <= imem_rdata;
            ifid_pc4   <= fetch_pc4;
         end else begin
            if (complete) begin
               skid_valid <= 1'b1;
               skid_instr <= imem_rdata;
               skid_pc4   <= fetch_pc4;
            end
            if (can_load)
               ifid_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a random run checked
// against an in-order program-stream model with flush redirects.
module tb_if_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic [29:0] pc;
   logic        pc_write;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        id_stall;
   logic        flush;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [29:0] ifid_pc4;

   logic [29:0] pc_reset;
   logic [29:0] target;
   int          ws;
   bit          rnd_mode;
   bit          rnd_ack;
   int          cnt;

   int          checks;
   int          errors;
   int          consumed;
   logic [29:0] exp_pc;
   bit          hold_valid;
   logic [29:0] hold_addr;

   function automatic logic [31:0] mem_word(input logic [29:0] a);
      return {a, 2'b01} ^ 32'hC3A5_5A3C;
   endfunction

   if_fetch_unit #(.NOP_INSTR(NOP)) dut (
      .clk       (clk),
      .rst       (rst),
      .pc        (pc),
      .pc_write  (pc_write),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ack  (imem_ack),
      .imem_rdata(imem_rdata),
      .id_stall  (id_stall),
      .flush     (flush),
      .ifid_valid(ifid_valid),
      .ifid_instr(ifid_instr),
      .ifid_pc4  (ifid_pc4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PC register: loads NPC (pc+1 or flush target) on pc_write
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc <= pc_reset;
      else if (pc_write)
         pc <= flush ? target : pc + 30'd1;
   end

   // memory: fixed wait states or random ack
   assign imem_ack   = imem_req && (rnd_mode ? rnd_ack : (cnt >= ws));
   assign imem_rdata = mem_word(imem_addr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= 0;
      else if (imem_req && !imem_ack)
         cnt <= cnt + 1;
      else
         cnt <= 0;
   end

   task automatic monitor();
      if (hold_valid && imem_req) begin
         checks++;
         if (imem_addr !== hold_addr) begin
            errors++;
            $display("FAIL req_stable: addr=%h want %h", imem_addr, hold_addr);
         end
      end
      hold_valid = imem_req && !imem_ack;
      hold_addr  = imem_addr;
      if (flush) begin
         exp_pc = target;
      end else if (ifid_valid && !id_stall) begin
         checks++;
         if (ifid_pc4 !== exp_pc + 30'd1 || ifid_instr !== mem_word(exp_pc)) begin
            errors++;
            $display("FAIL stream_order: pc4=%h instr=%h want %h %h",
                     ifid_pc4, ifid_instr, exp_pc + 30'd1, mem_word(exp_pc));
         end
         exp_pc = exp_pc + 30'd1;
         consumed++;
      end
   endtask

   task automatic tick();
      #1;
      monitor();
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [29:0] p);
      rst      = 1'b1;
      flush    = 1'b0;
      id_stall = 1'b0;
      rnd_ack  = 1'b0;
      pc_reset = p;
      @(negedge clk);
      @(negedge clk);
      rst        = 1'b0;
      exp_pc     = p;
      hold_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      flush    = 1'b0;
      id_stall = 1'b0;
      target   = 30'd0;
      pc_reset = 30'h0c00;
      @(negedge clk);
      #1;
      checks++;
      if ({imem_req, ifid_valid, ifid_instr, ifid_pc4, pc_write} !==
          {1'b0, 1'b0, NOP, 30'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_vals: req=%b v=%b i=%h pc4=%h pcw=%b want 0 0 %h 0 0",
                  imem_req, ifid_valid, ifid_instr, ifid_pc4, pc_write, NOP);
      end
      flush = 1'b1;
      #1;
      checks++;
      if (pc_write !== 1'b1) begin
         errors++;
         $display("FAIL reset_pcw_flush: pcw=%b want 1", pc_write);
      end
      flush = 1'b0;
   endtask

   task automatic test_stream();
      ws = 0;
      rnd_mode = 0;
      do_reset(30'h0c00);
      tick();
      #1;
      checks++;
      if ({imem_req, imem_addr, pc_write} !== {1'b1, 30'h0c00, 1'b1}) begin
         errors++;
         $display("FAIL stream_first: req=%b addr=%h pcw=%b want 1 0c00 1",
                  imem_req, imem_addr, pc_write);
      end
      tick();
      for (int i = 1; i <= 4; i++) begin
         #1;
         checks++;
         if ({ifid_valid, ifid_pc4, pc_write} !== {1'b1, 30'(30'h0c00 + i), 1'b1}) begin
            errors++;
            $display("FAIL stream_%0d: v=%b pc4=%h pcw=%b want 1 %h 1",
                     i, ifid_valid, ifid_pc4, pc_write, 30'(30'h0c00 + i));
         end
         tick();
      end
   endtask

   task automatic test_wait_states();
      ws = 2;
      rnd_mode = 0;
      do_reset(30'h0c00);
      tick();
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if ({imem_req, imem_addr, pc_write, ifid_valid} !==
             {1'b1, 30'h0c00, c == 2, 1'b0}) begin
            errors++;
            $display("FAIL ws_cycle%0d: req=%b addr=%h pcw=%b v=%b",
                     c, imem_req, imem_addr, pc_write, ifid_valid);
         end
         tick();
      end
      #1;
      checks++;
      if ({ifid_valid, ifid_pc4} !== {1'b1, 30'h0c01}) begin
         errors++;
         $display("FAIL ws_load1: v=%b pc4=%h want 1 0c01", ifid_valid, ifid_pc4);
      end
      tick();
      for (int b = 0; b < 2; b++) begin
         #1;
         checks++;
         if (ifid_valid !== 1'b0) begin
            errors++;
            $display("FAIL ws_bubble%0d: v=%b want 0", b, ifid_valid);
         end
         tick();
      end
      #1;
      checks++;
      if ({ifid_valid, ifid_pc4} !== {1'b1, 30'h0c02}) begin
         errors++;
         $display("FAIL ws_load2: v=%b pc4=%h want 1 0c02", ifid_valid, ifid_pc4);
      end
      tick();
   endtask

   task automatic test_skid();
      ws = 0;
      rnd_mode = 0;
      do_reset(30'h0c00);
      tick();
      tick();
      id_stall = 1'b1;
      #1;
      checks++;
      if ({ifid_valid, ifid_pc4, pc_write} !== {1'b1, 30'h0c01, 1'b1}) begin
         errors++;
         $display("FAIL skid_capture: v=%b pc4=%h pcw=%b want 1 0c01 1",
                  ifid_valid, ifid_pc4, pc_write);
      end
      tick();
      for (int s = 1; s < 3; s++) begin
         #1;
         checks++;
         if ({imem_req, pc_write, ifid_valid, ifid_pc4} !== {1'b0, 1'b0, 1'b1, 30'h0c01}) begin
            errors++;
            $display("FAIL skid_hold%0d: req=%b pcw=%b v=%b pc4=%h", s,
                     imem_req, pc_write, ifid_valid, ifid_pc4);
         end
         tick();
      end
      id_stall = 1'b0;
      tick();
      #1;
      checks++;
      if ({imem_req, imem_addr, ifid_valid, ifid_pc4} !==
          {1'b1, 30'h0c02, 1'b1, 30'h0c02}) begin
         errors++;
         $display("FAIL skid_drain: req=%b addr=%h v=%b pc4=%h want 1 0c02 1 0c02",
                  imem_req, imem_addr, ifid_valid, ifid_pc4);
      end
      tick();
      #1;
      checks++;
      if ({ifid_valid, ifid_pc4} !== {1'b1, 30'h0c03}) begin
         errors++;
         $display("FAIL skid_resume: v=%b pc4=%h want 1 0c03", ifid_valid, ifid_pc4);
      end
      repeat (4) tick();
   endtask

   task automatic test_flush_drop();
      ws = 2;
      rnd_mode = 0;
      do_reset(30'h0c00);
      tick();
      flush  = 1'b1;
      target = 30'h2000;
      #1;
      checks++;
      if ({imem_req, imem_addr, pc_write} !== {1'b1, 30'h0c00, 1'b1}) begin
         errors++;
         $display("FAIL drop_flush: req=%b addr=%h pcw=%b want 1 0c00 1",
                  imem_req, imem_addr, pc_write);
      end
      tick();
      flush = 1'b0;
      #1;
      checks++;
      if ({imem_req, imem_addr, pc_write, ifid_valid} !== {1'b1, 30'h0c00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL drop_hold: req=%b addr=%h pcw=%b v=%b want 1 0c00 0 0",
                  imem_req, imem_addr, pc_write, ifid_valid);
      end
      tick();
      #1;
      checks++;
      if ({imem_ack, imem_addr, pc_write, ifid_valid} !== {1'b1, 30'h0c00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL drop_ack: ack=%b addr=%h pcw=%b v=%b want 1 0c00 0 0",
                  imem_ack, imem_addr, pc_write, ifid_valid);
      end
      tick();
      #1;
      checks++;
      if ({imem_req, imem_addr, ifid_valid} !== {1'b1, 30'h2000, 1'b0}) begin
         errors++;
         $display("FAIL drop_target: req=%b addr=%h v=%b want 1 2000 0",
                  imem_req, imem_addr, ifid_valid);
      end
      repeat (3) tick();
      #1;
      checks++;
      if ({ifid_valid, ifid_pc4} !== {1'b1, 30'h2001}) begin
         errors++;
         $display("FAIL drop_first: v=%b pc4=%h want 1 2001", ifid_valid, ifid_pc4);
      end
      tick();
   endtask

   task automatic test_flush_skid();
      ws = 0;
      rnd_mode = 0;
      do_reset(30'h0c00);
      tick();
      tick();
      id_stall = 1'b1;
      tick();
      flush  = 1'b1;
      target = 30'h3000;
      #1;
      checks++;
      if ({imem_req, pc_write} !== {1'b0, 1'b1}) begin
         errors++;
         $display("FAIL fskid_pcw: req=%b pcw=%b want 0 1", imem_req, pc_write);
      end
      tick();
      flush = 1'b0;
      #1;
      checks++;
      if ({ifid_valid, ifid_instr, imem_req, imem_addr} !== {1'b0, NOP, 1'b1, 30'h3000}) begin
         errors++;
         $display("FAIL fskid_clear: v=%b i=%h req=%b addr=%h want 0 %h 1 3000",
                  ifid_valid, ifid_instr, imem_req, imem_addr, NOP);
      end
      tick();
      flush  = 1'b1;
      target = 30'h0400;
      #1;
      checks++;
      if ({ifid_valid, ifid_pc4, imem_ack, pc_write} !== {1'b1, 30'h3001, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL fack_pre: v=%b pc4=%h ack=%b pcw=%b want 1 3001 1 1",
                  ifid_valid, ifid_pc4, imem_ack, pc_write);
      end
      tick();
      flush = 1'b0;
      #1;
      checks++;
      if ({ifid_valid, ifid_instr, imem_addr} !== {1'b0, NOP, 30'h0400}) begin
         errors++;
         $display("FAIL fack_post: v=%b i=%h addr=%h want 0 %h 0400",
                  ifid_valid, ifid_instr, imem_addr, NOP);
      end
      id_stall = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_async_reset();
      ws = 0;
      rnd_mode = 0;
      do_reset(30'h0c00);
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({imem_req, ifid_valid, ifid_instr, pc_write} !== {1'b0, 1'b0, NOP, 1'b0}) begin
         errors++;
         $display("FAIL async_rst: req=%b v=%b i=%h pcw=%b want 0 0 %h 0",
                  imem_req, ifid_valid, ifid_instr, pc_write, NOP);
      end
      do_reset(30'h3FFF_FFFF);
      tick();
      tick();
      #1;
      checks++;
      if ({ifid_valid, ifid_pc4} !== {1'b1, 30'd0}) begin
         errors++;
         $display("FAIL wrap_pc4: v=%b pc4=%h want 1 0", ifid_valid, ifid_pc4);
      end
      tick();
      #1;
      checks++;
      if ({ifid_valid, ifid_pc4} !== {1'b1, 30'd1}) begin
         errors++;
         $display("FAIL wrap_next: v=%b pc4=%h want 1 1", ifid_valid, ifid_pc4);
      end
      tick();
   endtask

   task automatic test_random();
      rnd_mode = 1;
      do_reset(30'($urandom));
      consumed = 0;
      for (int n = 0; n < 600; n++) begin
         rnd_ack  = ($urandom_range(0, 1) == 1);
         id_stall = ($urandom_range(0, 3) == 0);
         flush    = ($urandom_range(0, 24) == 0);
         target   = 30'($urandom);
         tick();
      end
      flush    = 1'b0;
      id_stall = 1'b0;
      rnd_mode = 0;
      checks++;
      if (consumed < 60) begin
         errors++;
         $display("FAIL random_progress: consumed=%0d want >= 60", consumed);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      checks     = 0;
      errors     = 0;
      consumed   = 0;
      ws         = 0;
      rnd_mode   = 0;
      rnd_ack    = 0;
      hold_valid = 0;
      hold_addr  = 30'd0;
      exp_pc     = 30'd0;
      test_reset();
      test_stream();
      test_wait_states();
      test_skid();
      test_flush_drop();
      test_flush_skid();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage between the PC register and the ID stage of the 5-stage MIPS pipeline.
- Takes the current word PC, issues one instruction-memory request at a time over a req/ack handshake, and loads the result into the IF/ID pipeline register.
- Drives pc_write back to the PC register so the PC advances only when a fetch completes or a flush redirects it.
- Contains a 1-entry skid buffer for ID stalls, and handles branch/jump flush including a request already in flight.

Parameters:
NOP_INSTR, 32'h00000000, value of ifid_instr and skid instruction after reset or flush

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
pc  input  30  current word PC [31:2] from PC register
pc_write  output  1  PC update enable to PC register (1 = load NPC)
imem_req  output  1  instruction-memory request
imem_addr  output  30  instruction word address [31:2]
imem_ack  input  1  memory completes request this cycle; imem_rdata valid
imem_rdata  input  32  instruction word
id_stall  input  1  hazard unit: hold IF/ID contents
flush  input  1  redirect (taken branch/jump): squash IF and IF/ID; NPC holds target
ifid_valid  output  1  IF/ID holds a real instruction
ifid_instr  output  32  IF/ID instruction
ifid_pc4  output  30  IF/ID fetch address + 1 word [31:2]

Behaviour:
- Reset is asynchronous, active-high, clock clk.
  - Reset values: state=IDLE, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc4=0, skid_valid=0, skid instr=NOP_INSTR, drop_addr=0.
  - imem_req=0. pc_write=flush; the PC register is itself in reset.
- States: IDLE (no request), WAIT (request for address pc outstanding), DROP (squashed request outstanding).
- Outputs:
  - imem_req = (state==WAIT || state==DROP).
  - imem_addr = drop_addr in DROP, else pc.
  - The handshake requires req and addr stable until ack. In WAIT this holds because pc_write=0 until ack.
- can_load = !ifid_valid || !id_stall.
- complete = state==WAIT && imem_ack && !flush.
- pc_write = complete || flush (combinational).
- Zero-wait memory (ack in the same cycle as req) is legal. Sustained rate is 1 instruction/cycle.
- IDLE:
  - Goes to WAIT when !skid_valid, or when the skid drains this cycle (can_load && !flush).
  - On flush, the skid is cleared and the next state is WAIT.
- WAIT & complete:
  - If skid_valid (draining), or if !can_load: the word goes to skid, or stays in skid while the skid word moves to IF/ID. Next state is IDLE when the skid is left occupied.
  - Otherwise ifid <= {1, imem_rdata, pc+1}; stay in WAIT and issue the next PC the following cycle.
- WAIT & flush & imem_ack: data is discarded; stay in WAIT. The next request uses the target PC.
- WAIT & flush & !imem_ack: drop_addr <= pc; next state DROP.
- DROP:
  - Request is held at drop_addr.
  - On imem_ack, data is discarded and the next state is WAIT.
  - A flush in DROP pulses pc_write again and stays in DROP unless ack is also high (then WAIT).
- IF/ID update priority: flush > load (skid first, then memory) > hold (id_stall && ifid_valid) > bubble (ifid_valid <= 0).
  - Flush sets ifid_valid=0, skid_valid=0, ifid_instr=NOP_INSTR.
  - ifid_pc4 is the fetch address + 1, modulo 2^30 (30'h3FFFFFFF wraps to 0).
- Ordering: no instruction is lost or duplicated. Program order is IF/ID, then skid, then memory.
- Asynchronous reset mid-request abandons the request. imem_req drops immediately without waiting for a clock edge.

Test Plan:
1. Release rst, imem_ack tied to imem_req, PC reset 30'h0c00 → first request imem_addr=30'h0c00. Next edge: ifid_pc4=30'h0c01, ifid_valid=1. pc_write=1 every cycle; 4 consecutive instructions in 4 cycles.
2. Memory with 2 wait states → imem_req held 3 cycles, imem_addr constant, pc_write high only on the ack cycle, ifid_valid bubbles for 2 cycles.
3. Zero-wait memory, id_stall=1 for 3 cycles → one word captured in skid, then imem_req=0 and pc_write=0. Release stall → skid word into IF/ID, request resumes next cycle, sequence 0c01,0c02,0c03,... with no gap or duplicate.
4. 2-wait memory, flush asserted in the first wait cycle → pc_write=1 that cycle, state DROP, imem_addr stays old value until ack. Acked data is discarded. Next request is at the target address, and ifid_valid=0 throughout.
5. flush coincident with imem_ack and id_stall=1 with skid full → ifid_valid=0, skid emptied, ifid_instr=NOP_INSTR, pc_write=1, next request at the target.
6. rst asserted mid-WAIT between clock edges → imem_req=0 and ifid_valid=0 immediately. pc=30'h3FFFFFFF fetch → ifid_pc4=0.
